// File: rtl/mem_arb_pkg.sv
// Shared types for the memory access arbiter: response owner tags and grant encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_t;

  localparam logic [1:0] GNT_NONE  = 2'd0;
  localparam logic [1:0] GNT_FETCH = 2'd1;
  localparam logic [1:0] GNT_LOAD  = 2'd2;
  localparam logic [1:0] GNT_STORE = 2'd3;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of back-to-back data grants taken while a fetch was waiting.
module arb_streak_counter #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int CNT_W = $clog2(MAX_DATA_STREAK + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_sat) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_sat = (r_count == CNT_W'(MAX_DATA_STREAK));

endmodule

// File: rtl/mem_access_arbiter.sv
// Single-port memory arbiter for fetch, load and store with 1-cycle read response routing.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_SIZE       = 32,
  parameter int ADRS_SIZE       = 11,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic [ADRS_SIZE-1:0] fetch_adrs,
  input  logic                 fifo_full,
  input  logic                 branch_flush,
  output logic                 fetch_grant,
  output logic                 fetch_valid,
  output logic [DATA_SIZE-1:0] fetch_data,
  input  logic                 ld_req,
  input  logic [ADRS_SIZE-1:0] ld_adrs,
  output logic                 ld_grant,
  output logic                 ld_valid,
  output logic [DATA_SIZE-1:0] ld_data,
  input  logic                 st_req,
  input  logic [ADRS_SIZE-1:0] st_adrs,
  input  logic [DATA_SIZE-1:0] st_data,
  output logic                 st_grant,
  output logic [ADRS_SIZE-1:0] mem_adrs,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic [DATA_SIZE-1:0] mem_w_data,
  input  logic                 mem_r_valid,
  input  logic [DATA_SIZE-1:0] mem_data_out
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]          fetch_stall_cnt,
  output logic [31:0]          data_grant_cnt,
  output logic [31:0]          forced_fetch_cnt
`endif
);

  logic       w_fetch_elig;
  logic       w_sat;
  logic       w_force;
  logic       w_data_gnt;
  logic       w_resp_live;
  logic [1:0] w_gnt;
  owner_t     r_owner;

  assign w_fetch_elig = fetch_req & ~fifo_full & ~branch_flush;
  assign w_force      = w_sat & w_fetch_elig;

  // Store beats load beats fetch, unless a waiting fetch has been starved long enough.
  always_comb begin
    // NOTE: a default assignment up front keeps every path assigned, so no latch is inferred.
    w_gnt = GNT_NONE;
    if (reset)             w_gnt = GNT_NONE;
    else if (w_force)      w_gnt = GNT_FETCH;
    else if (st_req)       w_gnt = GNT_STORE;
    else if (ld_req)       w_gnt = GNT_LOAD;
    else if (w_fetch_elig) w_gnt = GNT_FETCH;
  end

  assign fetch_grant = (w_gnt == GNT_FETCH);
  assign ld_grant    = (w_gnt == GNT_LOAD);
  assign st_grant    = (w_gnt == GNT_STORE);
  assign w_data_gnt  = ld_grant | st_grant;

  always_comb begin
    mem_adrs   = '0;
    mem_w_data = '0;
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    case (w_gnt)
      GNT_STORE: begin
        mem_adrs   = st_adrs;
        mem_w_data = st_data;
        mem_w_en   = 1'b1;
      end
      GNT_LOAD: begin
        mem_adrs = ld_adrs;
        mem_r_en = 1'b1;
      end
      GNT_FETCH: begin
        mem_adrs = fetch_adrs;
        mem_r_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_NONE;
    end else begin
      case (w_gnt)
        GNT_FETCH: r_owner <= OWN_FETCH;
        GNT_LOAD:  r_owner <= OWN_LOAD;
        default:   r_owner <= OWN_NONE;
      endcase
    end
  end

  // A response arriving during reset, or for a flushed fetch, is dropped here.
  assign w_resp_live = mem_r_valid & ~reset;
  assign fetch_valid = w_resp_live & (r_owner == OWN_FETCH) & ~branch_flush;
  assign ld_valid    = w_resp_live & (r_owner == OWN_LOAD);
  assign fetch_data  = fetch_valid ? mem_data_out : '0;
  assign ld_data     = ld_valid ? mem_data_out : '0;

  arb_streak_counter #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_streak (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_data_gnt & w_fetch_elig),
    .i_clr (fetch_grant | ~w_fetch_elig),
    .o_sat (w_sat)
  );

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_fetch_stall_cnt;
  logic [31:0] r_data_grant_cnt;
  logic [31:0] r_forced_fetch_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_stall_cnt  <= '0;
      r_data_grant_cnt   <= '0;
      r_forced_fetch_cnt <= '0;
    end else begin
      if (w_fetch_elig && !fetch_grant) r_fetch_stall_cnt  <= r_fetch_stall_cnt + 32'd1;
      if (w_data_gnt)                   r_data_grant_cnt   <= r_data_grant_cnt + 32'd1;
      if (w_force)                      r_forced_fetch_cnt <= r_forced_fetch_cnt + 32'd1;
    end
  end

  assign fetch_stall_cnt  = r_fetch_stall_cnt;
  assign data_grant_cnt   = r_data_grant_cnt;
  assign forced_fetch_cnt = r_forced_fetch_cnt;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: memory model plus a response scoreboard.
module tb_mem_access_arbiter;

  localparam int DW = 32;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req, fifo_full, branch_flush;
  logic [AW-1:0] fetch_adrs;
  logic          fetch_grant, fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          ld_req, ld_grant, ld_valid;
  logic [AW-1:0] ld_adrs;
  logic [DW-1:0] ld_data;
  logic          st_req, st_grant;
  logic [AW-1:0] st_adrs;
  logic [DW-1:0] st_data;
  logic [AW-1:0] mem_adrs;
  logic          mem_r_en, mem_w_en;
  logic [DW-1:0] mem_w_data;
  logic          mem_r_valid_model, inject_r_valid, w_mem_r_valid;
  logic [DW-1:0] mem_data_out;

  logic [DW-1:0] mem_arr [0:2047];
  logic          written [0:2047];

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [DW-1:0] fetch_q [$];
  logic [DW-1:0] ld_q [$];
  logic [DW-1:0] shadow [int];
  bit            pend_f = 1'b0;
  bit            pend_l = 1'b0;

  always #5 clk = ~clk;

  assign w_mem_r_valid = mem_r_valid_model | inject_r_valid;

  mem_access_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_adrs   (fetch_adrs),
    .fifo_full    (fifo_full),
    .branch_flush (branch_flush),
    .fetch_grant  (fetch_grant),
    .fetch_valid  (fetch_valid),
    .fetch_data   (fetch_data),
    .ld_req       (ld_req),
    .ld_adrs      (ld_adrs),
    .ld_grant     (ld_grant),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .st_req       (st_req),
    .st_adrs      (st_adrs),
    .st_data      (st_data),
    .st_grant     (st_grant),
    .mem_adrs     (mem_adrs),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .mem_w_data   (mem_w_data),
    .mem_r_valid  (w_mem_r_valid),
    .mem_data_out (mem_data_out)
  );

  function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {21'd0, a};
  endfunction

  function automatic logic [DW-1:0] exp_mem(input logic [AW-1:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return mem_init(a);
  endfunction

  // Synchronous memory with one-cycle read latency; unwritten words hold mem_init().
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2048; i++) written[i] <= 1'b0;
    end else if (mem_w_en) begin
      mem_arr[mem_adrs] <= mem_w_data;
      written[mem_adrs] <= 1'b1;
    end
    mem_r_valid_model <= mem_r_en;
    mem_data_out      <= written[mem_adrs] ? mem_arr[mem_adrs] : mem_init(mem_adrs);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check grants and port, score responses, queue expected read data.
  task automatic cycle(input bit efg, input bit elg, input bit esg);
    logic [DW-1:0] d;
    bit            fv_exp;
    bit            lv_exp;
    @(negedge clk);
    check("fetch_grant", 32'(fetch_grant), 32'(efg));
    check("ld_grant",    32'(ld_grant),    32'(elg));
    check("st_grant",    32'(st_grant),    32'(esg));
    check("mem_r_en",    32'(mem_r_en),    32'(efg | elg));
    check("mem_w_en",    32'(mem_w_en),    32'(esg));
    if (esg) begin
      check("mem_adrs_st", 32'(mem_adrs), 32'(st_adrs));
      check("mem_w_data",  mem_w_data,    st_data);
    end else if (elg) begin
      check("mem_adrs_ld", 32'(mem_adrs), 32'(ld_adrs));
    end else if (efg) begin
      check("mem_adrs_fetch", 32'(mem_adrs), 32'(fetch_adrs));
    end
    fv_exp = pend_f && !branch_flush && !reset;
    lv_exp = pend_l && !reset;
    check("fetch_valid", 32'(fetch_valid), 32'(fv_exp));
    check("ld_valid",    32'(ld_valid),    32'(lv_exp));
    if (pend_f) begin
      d = fetch_q.pop_front();
      if (fv_exp) check("fetch_data", fetch_data, d);
    end
    if (pend_l) begin
      d = ld_q.pop_front();
      if (lv_exp) check("ld_data", ld_data, d);
    end
    if (reset) begin
      check("rst_mem_adrs",   32'(mem_adrs), 32'd0);
      check("rst_mem_w_data", mem_w_data,    32'd0);
      check("rst_fetch_data", fetch_data,    32'd0);
      check("rst_ld_data",    ld_data,       32'd0);
      shadow.delete();
    end
    pend_f = efg && !reset;
    pend_l = elg && !reset;
    if (pend_f) fetch_q.push_back(exp_mem(fetch_adrs));
    if (pend_l) ld_q.push_back(exp_mem(ld_adrs));
    if (esg && !reset) shadow[int'(st_adrs)] = st_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    fetch_req      = 1'b0;
    fetch_adrs     = '0;
    fifo_full      = 1'b0;
    branch_flush   = 1'b0;
    ld_req         = 1'b0;
    ld_adrs        = '0;
    st_req         = 1'b0;
    st_adrs        = '0;
    st_data        = '0;
    inject_r_valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds every output low even with all requesters asking.
    fetch_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
    st_adrs = 11'h7; st_data = 32'h1234_5678; ld_adrs = 11'h3; fetch_adrs = 11'h2;
    cycle(0, 0, 0);
    reset = 1'b0; fetch_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    cycle(0, 0, 0);

    // Fetch alone streams addresses 0..5.
    fetch_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fetch_adrs = AW'(i);
      cycle(1, 0, 0);
    end
    fetch_req = 1'b0;
    cycle(0, 0, 0);

    // Store, load and fetch together; load reads the freshly stored word.
    st_req = 1'b1; st_adrs = 11'h010; st_data = 32'hDEAD_BEEF;
    ld_req = 1'b1; ld_adrs = 11'h010;
    fetch_req = 1'b1; fetch_adrs = 11'h030;
    cycle(0, 0, 1);
    st_req = 1'b0;
    cycle(0, 1, 0);
    ld_req = 1'b0;
    cycle(1, 0, 0);
    fetch_req = 1'b0;
    cycle(0, 0, 0);

    // Stray read-valid with no owner raises nothing.
    inject_r_valid = 1'b1;
    cycle(0, 0, 0);
    inject_r_valid = 1'b0;

    // Continuous loads with an eligible fetch: fetch forced after every 4 loads.
    ld_req = 1'b1; ld_adrs = 11'h040;
    fetch_req = 1'b1; fetch_adrs = 11'h100;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) begin
        cycle(1, 0, 0);
        fetch_adrs = fetch_adrs + AW'(1);
      end else begin
        cycle(0, 1, 0);
      end
    end
    ld_req = 1'b0; fetch_req = 1'b0;
    cycle(0, 0, 0);

    // Branch flush kills the in-flight fetch and blocks a new fetch grant.
    fetch_req = 1'b1; fetch_adrs = 11'h020;
    cycle(1, 0, 0);
    branch_flush = 1'b1; fetch_adrs = 11'h080;
    cycle(0, 0, 0);
    branch_flush = 1'b0;
    cycle(1, 0, 0);
    fetch_req = 1'b0;
    cycle(0, 0, 0);

    // FIFO full: fetch ineligible, streak must stay 0 through many loads.
    fifo_full = 1'b1; fetch_req = 1'b1; fetch_adrs = 11'h200;
    ld_req = 1'b1; ld_adrs = 11'h060;
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);
    fifo_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) cycle(1, 0, 0);
      else        cycle(0, 1, 0);
    end
    ld_req = 1'b0; fifo_full = 1'b1; fetch_adrs = 11'h201;
    cycle(0, 0, 0);
    fifo_full = 1'b0;
    cycle(1, 0, 0);
    fetch_req = 1'b0;
    cycle(0, 0, 0);

    // Reset in the cycle after a load grant discards the response.
    ld_req = 1'b1; ld_adrs = 11'h050;
    cycle(0, 1, 0);
    ld_req = 1'b0; reset = 1'b1;
    cycle(0, 0, 0);
    reset = 1'b0;
    cycle(0, 0, 0);

    check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    check("ld_q_drained",    32'(ld_q.size()),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares the single system-clock memory port between three requesters: the instruction-fetch path (PC → async FIFO write side), CPU loads and CPU stores.
- Issues one memory access per cycle and routes each 1-cycle-latency read response back to the requester that issued it.
- Drops a fetch response still in flight when a branch redirects the PC.
- Sits in the sys_clk domain, between the PC, memory and FIFO write port.

Parameters:
- DATA_SIZE, 32, memory data width.
- ADRS_SIZE, 11, memory address width.
- MAX_DATA_STREAK, 4, maximum consecutive load/store grants while a fetch is eligible before fetch is forced one grant.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  PC has an instruction address to read.
- fetch_adrs  in  ADRS_SIZE  instruction address from the PC.
- fifo_full  in  1  instruction FIFO full; blocks fetch eligibility.
- branch_flush  in  1  branch_valid from the CPU; kills the in-flight fetch response.
- fetch_grant  out  1  fetch accepted this cycle; the PC advances.
- fetch_valid  out  1  fetch data valid; drives FIFO w_en.
- fetch_data  out  DATA_SIZE  instruction word to the FIFO.
- ld_req  in  1  CPU load request.
- ld_adrs  in  ADRS_SIZE  load address.
- ld_grant  out  1  load accepted.
- ld_valid  out  1  load data valid.
- ld_data  out  DATA_SIZE  load data.
- st_req  in  1  CPU store request.
- st_adrs  in  ADRS_SIZE  store address.
- st_data  in  DATA_SIZE  store data.
- st_grant  out  1  store accepted; the write occurs this cycle.
- mem_adrs  out  ADRS_SIZE  memory address.
- mem_r_en  out  1  memory read enable.
- mem_w_en  out  1  memory write enable.
- mem_w_data  out  DATA_SIZE  memory write data.
- mem_r_valid  in  1  memory read data valid, one cycle after mem_r_en.
- mem_data_out  in  DATA_SIZE  memory read data.

Behaviour:
- Reset: all grants, valids, mem_r_en and mem_w_en are 0; mem_adrs, mem_w_data, fetch_data and ld_data are 0; the owner register is OWN_NONE; the streak counter is 0.
- Eligibility:
  - fetch_elig = fetch_req & !fifo_full & !branch_flush.
  - ld_elig = ld_req.
  - st_elig = st_req.
- Priority: store > load > fetch.
  - Exception: when the streak counter equals MAX_DATA_STREAK and fetch_elig is high, fetch wins that cycle.
- Grant timing:
  - Exactly one grant per cycle at most.
  - Grants are combinational from the current requests and registered state.
  - mem_adrs, mem_r_en and mem_w_en are driven in the same cycle as the grant.
  - A requester holds req/adrs/data stable until it sees its grant.
- Streak counter:
  - Increments on each load/store grant while fetch_elig is high, saturating at MAX_DATA_STREAK.
  - Clears on a fetch grant, and on any cycle in which fetch_elig is low.
- Owner register (pipeline stage):
  - Set to OWN_FETCH, OWN_LOAD or OWN_NONE when a read is granted, or when nothing or a store is granted.
  - In the next cycle, mem_r_valid plus the owner produce the matching *_valid pulse; data is registered-through combinationally from mem_data_out.
- Flush:
  - branch_flush high while owner == OWN_FETCH → fetch_valid is suppressed for that response.
  - A fetch grant is never issued in a branch_flush cycle.
- mem_r_valid while owner is OWN_NONE: ignored; no valid is raised.
- Simultaneous st_req and ld_req to the same address: the store is granted first, and the load is granted no earlier than the next cycle, so the load reads the new data.
- Reset asserted mid-read: the pending response is discarded and no valid is raised the following cycle.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs fetch_stall_cnt (32), data_grant_cnt (32) and forced_fetch_cnt (32).
  - fetch_stall_cnt counts cycles with fetch_elig high and no fetch grant.
  - data_grant_cnt counts load plus store grants.
  - forced_fetch_cnt counts streak-forced fetch grants.
  - All counters clear on reset and wrap at 2^32.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_FETCH, OWN_LOAD}.
  - localparam for the grant encoding.
- One sub-module: arb_streak_counter, a saturating counter with inc, clr and sat outputs, parameterised by MAX_DATA_STREAK.

Test Plan:
- Only fetch_req, fifo_full=0, fetch_adrs 0..5: fetch_grant every cycle, and fetch_valid 1 cycle later with the data at each address in order.
- st_req, ld_req and fetch_req all high in the same cycle, store to 0x010 with data 0xDEADBEEF and load from 0x010: cycle0 st_grant; cycle1 ld_grant; cycle2 ld_data=0xDEADBEEF and fetch_grant.
- ld_req held high for 10 cycles with fetch eligible, MAX_DATA_STREAK=4: a fetch grant appears after every 4 load grants (cycles 4 and 9).
- fetch granted at adrs 0x020, branch_flush=1 the next cycle: no fetch_valid for 0x020, and no fetch grant that cycle.
- fifo_full=1 with fetch_req=1: no fetch_grant and the streak counter stays 0; fifo_full drops → fetch_grant in the same cycle.
- reset=1 in the cycle after ld_grant: ld_valid stays 0 and all outputs return to reset values.
